// File: rtl/otbn_x1_call_stack_if.sv
// Request/status bundle for the OTBN x1 call stack.
// The master drives push/pop/clear requests; the slave (the stack) returns top-of-stack and status.
interface otbn_x1_call_stack_if #(
  parameter int unsigned BaseIntgWidth = 39
);
  logic                     clear_i;
  logic                     push_i;
  logic [BaseIntgWidth-1:0] push_data_i;
  logic                     pop_i;
  logic [BaseIntgWidth-1:0] top_data_o;
  logic                     top_valid_o;
  logic                     full_o;
  logic                     empty_o;
  logic                     err_o;

  modport master (
    output clear_i, push_i, push_data_i, pop_i,
    input  top_data_o, top_valid_o, full_o, empty_o, err_o
  );

  modport slave (
    input  clear_i, push_i, push_data_i, pop_i,
    output top_data_o, top_valid_o, full_o, empty_o, err_o
  );
endinterface

// File: rtl/otbn_x1_call_stack.sv
// Hardware call stack backing GPR x1: writes push, reads pop, overflow/underflow raise a registered error.
// Optional macro OTBN_CALL_STACK_ERR_STICKY_EN keeps err_o high until reset or clear.
module otbn_x1_call_stack #(
  parameter int unsigned StackDepth  = 8,
  parameter logic [38:0] WordZeroVal = '0
) (
  input logic                   clk_i,
  input logic                   rst_i,
  otbn_x1_call_stack_if.slave   bus
);

  localparam int unsigned BaseIntgWidth = 39;
  localparam int unsigned CntW          = $clog2(StackDepth + 1);
  localparam int unsigned IdxW          = $clog2(StackDepth);
  localparam logic [CntW-1:0] DepthCnt  = CntW'(StackDepth);

  logic [BaseIntgWidth-1:0] stack_q [StackDepth];
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic                     err_q, err_d;
  logic                     err_evt;
  logic                     stack_we;
  logic [IdxW-1:0]          stack_waddr;
  logic [IdxW-1:0]          top_idx;
  logic                     is_empty;
  logic                     is_full;

  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == DepthCnt);
  assign top_idx  = IdxW'(cnt_q - CntW'(1));

  // Clear wins over push/pop; push+pop on a non-empty stack replaces the top in place.
  always_comb begin
    cnt_d       = cnt_q;
    err_evt     = 1'b0;
    stack_we    = 1'b0;
    stack_waddr = '0;
    if (bus.clear_i) begin
      cnt_d = '0;
    end else if (bus.pop_i && is_empty) begin
      err_evt = 1'b1;
    end else if (bus.push_i && bus.pop_i) begin
      stack_we    = 1'b1;
      stack_waddr = top_idx;
    end else if (bus.push_i) begin
      if (is_full) begin
        err_evt = 1'b1;
      end else begin
        stack_we    = 1'b1;
        stack_waddr = IdxW'(cnt_q);
        cnt_d       = cnt_q + CntW'(1);
      end
    end else if (bus.pop_i) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_comb begin
    err_d = 1'b0;
`ifdef OTBN_CALL_STACK_ERR_STICKY_EN
    if (!bus.clear_i) begin
      err_d = err_q | err_evt;
    end
`else
    err_d = err_evt;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Entry storage is deliberately unreset; cnt alone defines which entries are live.
  always_ff @(posedge clk_i) begin
    if (stack_we && !rst_i) begin
      stack_q[stack_waddr] <= bus.push_data_i;
    end
  end

  assign bus.top_data_o  = is_empty ? WordZeroVal : stack_q[top_idx];
  assign bus.top_valid_o = !is_empty;
  assign bus.full_o      = is_full;
  assign bus.empty_o     = is_empty;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_otbn_x1_call_stack.sv
// Self-checking bench for otbn_x1_call_stack: directed scenarios plus random traffic,
// compared each cycle against a queue-based reference model.
module tb_otbn_x1_call_stack;

  localparam int unsigned Depth = 8;
  localparam logic [38:0] ZeroVal = '0;

  logic clk;
  logic rst;
  int   test_count;
  int   fail_count;

  logic [38:0] model_q [$];
  logic        model_err;

  otbn_x1_call_stack_if #(.BaseIntgWidth(39)) bus ();

  otbn_x1_call_stack #(
    .StackDepth (Depth),
    .WordZeroVal(ZeroVal)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic compareAll();
    logic [38:0] exp_top;
    exp_top = (model_q.size() == 0) ? ZeroVal : model_q[model_q.size()-1];
    checkOutput("top_data",  64'(bus.top_data_o),  64'(exp_top));
    checkOutput("top_valid", 64'(bus.top_valid_o), 64'(model_q.size() != 0));
    checkOutput("full",      64'(bus.full_o),      64'(model_q.size() == Depth));
    checkOutput("empty",     64'(bus.empty_o),     64'(model_q.size() == 0));
    checkOutput("err",       64'(bus.err_o),       64'(model_err));
  endtask

  // Reference behaviour expressed directly as stack operations on a queue.
  task automatic modelStep(input logic r, input logic c, input logic pu, input logic po,
                           input logic [38:0] d);
    logic evt;
    evt = 1'b0;
    if (r) begin
      model_q.delete();
      model_err = 1'b0;
      return;
    end
    if (c) begin
      model_q.delete();
      model_err = 1'b0;
      return;
    end
    if (po && model_q.size() == 0) evt = 1'b1;
    else if (pu && po) model_q[model_q.size()-1] = d;
    else if (pu) begin
      if (model_q.size() == Depth) evt = 1'b1;
      else model_q.push_back(d);
    end else if (po) void'(model_q.pop_back());
`ifdef OTBN_CALL_STACK_ERR_STICKY_EN
    model_err = model_err | evt;
`else
    model_err = evt;
`endif
  endtask

  task automatic applyStimulus(input logic r, input logic c, input logic pu, input logic po,
                               input logic [38:0] d);
    rst             = r;
    bus.clear_i     = c;
    bus.push_i      = pu;
    bus.pop_i       = po;
    bus.push_data_i = d;
    @(posedge clk);
    modelStep(r, c, pu, po, d);
    #1;
    rst             = 1'b0;
    bus.clear_i     = 1'b0;
    bus.push_i      = 1'b0;
    bus.pop_i       = 1'b0;
    bus.push_data_i = '0;
    compareAll();
  endtask

  initial begin
    test_count = 0;
    fail_count = 0;
    model_err  = 1'b0;
    rst = 1'b0;
    bus.clear_i = 1'b0;
    bus.push_i = 1'b0;
    bus.pop_i = 1'b0;
    bus.push_data_i = '0;
    #2;

    applyStimulus(1, 0, 0, 0, '0);
    checkOutput("reset_empty", 64'(bus.empty_o), 64'd1);

    // Basic LIFO ordering
    applyStimulus(0, 0, 1, 0, 39'h11);
    checkOutput("push1_top", 64'(bus.top_data_o), 64'h11);
    applyStimulus(0, 0, 1, 0, 39'h22);
    applyStimulus(0, 0, 1, 0, 39'h33);
    checkOutput("push3_top", 64'(bus.top_data_o), 64'h33);
    applyStimulus(0, 0, 0, 1, '0);
    checkOutput("pop1_top", 64'(bus.top_data_o), 64'h22);
    applyStimulus(0, 0, 0, 1, '0);
    applyStimulus(0, 0, 0, 1, '0);
    checkOutput("pop3_empty", 64'(bus.empty_o), 64'd1);

    // Fill, overflow, then replace-top while full
    for (int i = 0; i < Depth; i++) applyStimulus(0, 0, 1, 0, 39'(i + 1));
    checkOutput("fill_full", 64'(bus.full_o), 64'd1);
    applyStimulus(0, 0, 1, 0, 39'hAA);
    checkOutput("ovf_err", 64'(bus.err_o), 64'd1);
    checkOutput("ovf_top", 64'(bus.top_data_o), 64'(Depth));
    applyStimulus(0, 0, 1, 1, 39'h55);
    checkOutput("swap_top", 64'(bus.top_data_o), 64'h55);
    checkOutput("swap_full", 64'(bus.full_o), 64'd1);

    // Underflow on empty, with and without push
    applyStimulus(0, 1, 0, 0, '0);
    applyStimulus(0, 0, 0, 1, '0);
    checkOutput("unf_err", 64'(bus.err_o), 64'd1);
    applyStimulus(0, 1, 0, 0, '0);
    applyStimulus(0, 0, 1, 1, 39'h77);
    checkOutput("unf_pp_err", 64'(bus.err_o), 64'd1);
    checkOutput("unf_pp_top", 64'(bus.top_data_o), 64'(ZeroVal));

    // Clear and reset beat a concurrent push
    applyStimulus(0, 1, 0, 0, '0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 39'(8'hC0 + i));
    applyStimulus(0, 1, 1, 0, 39'h99);
    checkOutput("clear_empty", 64'(bus.empty_o), 64'd1);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 1, 0, 39'(8'hD0 + i));
    applyStimulus(1, 0, 1, 0, 39'h99);
    checkOutput("rst_empty", 64'(bus.empty_o), 64'd1);

    // Underflow followed by idle cycles exposes pulse vs sticky error
    applyStimulus(0, 0, 0, 1, '0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, '0);
    applyStimulus(0, 1, 0, 0, '0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic r, c, pu, po;
      logic [38:0] d;
      r  = ($urandom_range(0, 99) < 2);
      c  = ($urandom_range(0, 99) < 4);
      pu = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 40);
      d  = {$urandom, $urandom};
      applyStimulus(r, c, pu, po, d);
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
